// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult
//
// Iterative shift-add multiplier. One partial product is added per clock, so
// a WIDTH x WIDTH multiply takes WIDTH cycles in CALC regardless of operand
// values. Valid/ready handshakes on both the operand and the product side.
//
// Optional feature macro: SEQ_MULT_SIGNED_EN
//    defined   -> signed_mode=1 at accept treats a and b as two's complement
//    undefined -> all operands unsigned, signed_mode is ignored
//
// Parameters:
//    WIDTH        operand width (>= 2), product is 2*WIDTH bits
//
// Ports:
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    in_valid     operands a, b, signed_mode are valid
//    in_ready     block can accept operands (high only in IDLE)
//    a            multiplicand
//    b            multiplier
//    signed_mode  1 = two's-complement operands (only with SEQ_MULT_SIGNED_EN)
//    out_valid    product is valid (registered)
//    out_ready    downstream accepts product
//    product      result, held until the next result overwrites it
//    busy         high in CALC or DONE
// ---------------------------------------------------------------------------
module seq_mult #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   // Counter must be able to hold the value WIDTH itself.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          state;
   logic [PW-1:0]   mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]   acc;
   logic [CW-1:0]   count;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [PW-1:0]   step_sum;
   logic [PW-1:0]   step_result;

`ifdef SEQ_MULT_SIGNED_EN
   logic neg;
   logic neg_in;

   // Magnitudes of the incoming operands. The most negative value maps to
   // 2^(WIDTH-1), which is still correct when read back as unsigned.
   assign mag_a  = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign mag_b  = (signed_mode && b[WIDTH-1]) ? -b : b;
   assign neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
   logic unused_signed_mode;

   assign mag_a              = a;
   assign mag_b              = b;
   assign unused_signed_mode = signed_mode;
`endif

   // Accumulator value after the current CALC step.
   assign step_sum = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MULT_SIGNED_EN
   assign step_result = neg ? -step_sum : step_sum;
`else
   assign step_result = step_sum;
`endif

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Main FSM: capture in IDLE, one shift-add per cycle in CALC, hold the
   // registered product in DONE until the downstream handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         product   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         neg       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= {{WIDTH{1'b0}}, mag_a};
                  mplier <= mag_b;
                  acc    <= '0;
                  count  <= CW'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
                  neg    <= neg_in;
`endif
                  state  <= CALC;
               end
            end
            CALC: begin
               acc    <= step_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - 1'b1;
               // Counter value 1 marks the final partial product.
               if (count == CW'(1)) begin
                  product   <= step_result;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised iterative shift-add multiplier with valid/ready handshakes on both sides. It generalises the team's fixed 4x4 registered multiplier. Operand width is a parameter, and the block computes one partial product per cycle so that large widths stay small in area. Signed operation can be compiled in with a macro. It sits between the tile's input pins and output pins, or inside larger datapaths, as a shared arithmetic unit.

## Interface

Parameters:
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a, b, signed_mode valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- signed_mode  in  1  1 = two's-complement operands (only honoured with SEQ_MULT_SIGNED_EN)
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- product  out  2*WIDTH  result
- busy  out  1  high in CALC or DONE

## Operation

- State machine: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture the operand magnitudes and the negate flag.
  - Clear the 2*WIDTH accumulator and load the iteration counter with WIDTH.
  - Go to CALC.
- CALC: one step per cycle.
  - If the multiplier LSB is 1, the accumulator adds the multiplicand (2*WIDTH wide).
  - The multiplicand shifts left by 1 and the multiplier shifts right by 1.
  - The counter decrements.
  - When the counter reaches 1, this step is the last. Go to DONE, and register product = accumulator result, negated if the negate flag is set.
- DONE:
  - out_valid=1.
  - product is held stable until out_valid & out_ready, then go to IDLE.
- in_ready is 1 only in IDLE. There is no accept in the same cycle as the DONE handshake.
- Arithmetic is modulo 2^(2*WIDTH), but no overflow is possible: the unsigned max (2^W−1)^2 fits, and signed (−2^(W−1))^2 = 2^(2W−2) fits.
- Signed magnitude: |−2^(W−1)| = 2^(W−1) is treated as an unsigned WIDTH-bit value, which gives the correct result.
- Zero operands get no early termination. Latency is always fixed.
- product remains at its last value after the handshake until the next result overwrites it.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, busy=0, product=0, with the accumulator, counter and operand registers cleared.
- Asserting rst_n low mid-CALC or mid-DONE aborts immediately. Outputs take their reset values asynchronously and the pending result is discarded.
- Inputs are ignored outside IDLE.

## Timing

- Accept edge T (in_valid & in_ready): CALC occupies edges T+1 … T+WIDTH.
- out_valid rises after edge T+WIDTH, so latency is WIDTH cycles from accept to out_valid.
- With out_ready held high, the DONE handshake happens at edge T+WIDTH+1. IDLE is then entered and in_ready=1 after that edge.
- The next accept is earliest at edge T+WIDTH+2. Peak throughput is one product per WIDTH+2 cycles.
- All outputs are registered except in_ready and busy, which are decoded from the state register.

## Configuration

- Macro: SEQ_MULT_SIGNED_EN.
- When defined:
  - With signed_mode=1 at accept, a and b are two's-complement.
  - Magnitudes are taken at capture, and the negate flag is a[W−1]^b[W−1].
  - The result is two's-complement in 2*WIDTH bits.
- When undefined:
  - signed_mode is ignored and all operands are unsigned.
  - No magnitude or negation logic is synthesised.
  - The port remains present.

## Test plan

WIDTH=4 unless noted:
- Unsigned max: a=0xF, b=0xF, signed_mode=0 -> out_valid exactly 4 cycles after the accept edge, product=0xE1 (225).
- Signed corner (macro on): a=0x8, b=0x8, signed_mode=1 -> product=0x40 (+64). Also a=0xD (−3), b=0x5 -> product=0xF1 (−15).
- Macro off: a=0xD, b=0x5, signed_mode=1 -> product=0x41 (65, unsigned).
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> product and out_valid stable, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> IDLE next cycle.
- Reset mid-CALC: drop rst_n 2 cycles after accept -> out_valid=0, product=0 and in_ready=1 immediately. After release, a=3, b=4 yields 0x0C normally.
- Back-to-back and width sweep: WIDTH=8, in_valid and out_ready held high. Run 0xFF*0xFF -> 0xFE01, then 0x00*0xAB -> 0x0000. Accepts are spaced exactly 10 cycles apart.
